// File: rtl/rr_rx_arbiter.sv
// Round-robin arbiter that moves bursts from per-channel RX FIFOs to the FT601 host port.
// Optional build macro RR_ARB_CH0_PRIORITY_EN gives channel 0 strict priority over the rest.
module rr_rx_arbiter #(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 16,
    parameter int GRANT_W      = $clog2(NUM_CHANNELS)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS-1:0]              rx_fifo_empty,
    input  logic [NUM_CHANNELS-1:0]              rx_fifo_almost_empty,
    input  logic [NUM_CHANNELS-1:0][DATA_W-1:0]  rx_fifo_data,
    input  logic                                 allow_rx,
    output logic [NUM_CHANNELS-1:0]              rx_fifo_rd,
    output logic [DATA_W-1:0]                    rx_data,
    output logic [GRANT_W-1:0]                   grant,
    output logic                                 rx_valid,
    output logic                                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam int              CW        = GRANT_W + 1;
    localparam logic [7:0]      LAST_WORD = 8'(BURST_LEN - 1);
    localparam logic [GRANT_W-1:0] LAST_CH = GRANT_W'(NUM_CHANNELS - 1);

    state_e               state_q;
    state_e               state_d;
    logic [GRANT_W-1:0]   grant_q;
    logic [GRANT_W-1:0]   grant_d;
    logic [GRANT_W-1:0]   last_grant_q;
    logic [GRANT_W-1:0]   last_grant_d;
    logic [7:0]           word_cnt_q;
    logic [7:0]           word_cnt_d;

    logic                 win_found;
    logic [GRANT_W-1:0]   win_idx;
    logic [CW-1:0]        cand;
    logic                 cur_empty;
    logic                 cur_almost_empty;
    logic                 rd_fire;
    logic                 arb_win;

    assign cur_empty        = rx_fifo_empty[grant_q];
    assign cur_almost_empty = rx_fifo_almost_empty[grant_q];
    assign rd_fire          = (state_q == ST_BURST) && allow_rx && !cur_empty;
    assign arb_win          = (state_q == ST_IDLE) && allow_rx && win_found;

    // Winner search: first non-empty channel above last_grant, wrapping modulo NUM_CHANNELS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef RR_ARB_CH0_PRIORITY_EN
        if (!rx_fifo_empty[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end else begin
            for (int i = 1; i <= NUM_CHANNELS; i++) begin
                cand = {1'b0, last_grant_q} + CW'(i);
                if (cand >= CW'(NUM_CHANNELS)) begin
                    cand = cand - CW'(NUM_CHANNELS);
                end else begin
                    cand = cand;
                end
                // Channel 0 is handled above, so the rotation skips it.
                if (!win_found && (cand != '0) && !rx_fifo_empty[cand[GRANT_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[GRANT_W-1:0];
                end else begin
                    win_found = win_found;
                end
            end
        end
`else
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            cand = {1'b0, last_grant_q} + CW'(i);
            if (cand >= CW'(NUM_CHANNELS)) begin
                cand = cand - CW'(NUM_CHANNELS);
            end else begin
                cand = cand;
            end
            if (!win_found && !rx_fifo_empty[cand[GRANT_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[GRANT_W-1:0];
            end else begin
                win_found = win_found;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bursts always fall back to IDLE so every new grant sees a fresh arbitration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_win) begin
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_BURST;
            end
            ST_BURST: begin
                if (!allow_rx || cur_empty) begin
                    state_d = ST_IDLE;
                end else if (cur_almost_empty || (word_cnt_q == LAST_WORD)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping and burst word counter.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        word_cnt_d   = word_cnt_q;
        if (arb_win) begin
            grant_d      = win_idx;
            last_grant_d = win_idx;
        end else begin
            grant_d      = grant_q;
            last_grant_d = last_grant_q;
        end
        if (state_q == ST_SETUP) begin
            word_cnt_d = 8'd0;
        end else if (rd_fire) begin
            word_cnt_d = word_cnt_q + 8'd1;
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Datapath registers; last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            word_cnt_q   <= 8'd0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    // Outputs: read strobe follows allow_rx in the same cycle and drops with reset via state_q.
    always_comb begin
        rx_fifo_rd = '0;
        if (rd_fire) begin
            rx_fifo_rd[grant_q] = 1'b1;
        end else begin
            rx_fifo_rd = '0;
        end
        rx_valid = |rx_fifo_rd;
        busy     = (state_q != ST_IDLE);
        rx_data  = rx_fifo_data[grant_q];
        grant    = grant_q;
    end

endmodule

// File: tb/tb_rr_rx_arbiter.sv
// Directed self-checking bench for rr_rx_arbiter; FIFOs modelled as push/pop counters.
module tb_rr_rx_arbiter;

    localparam int N  = 8;
    localparam int DW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         empty;
    logic [N-1:0]         aempty;
    logic [N-1:0][DW-1:0] fdata;
    logic                 allow;
    logic [N-1:0]         rd;
    logic [DW-1:0]        rx_data;
    logic [2:0]           grant;
    logic                 rx_valid;
    logic                 busy;

    int pushed [N];
    int popped [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_rx_arbiter dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rx_fifo_empty        (empty),
        .rx_fifo_almost_empty (aempty),
        .rx_fifo_data         (fdata),
        .allow_rx             (allow),
        .rx_fifo_rd           (rd),
        .rx_data              (rx_data),
        .grant                (grant),
        .rx_valid             (rx_valid),
        .busy                 (busy)
    );

    // FIFO pop side: each strobe consumes one word.
    always @(posedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (rd[c]) popped[c] <= popped[c] + 1;
        end
    end

    // FIFO flags and first-word-fall-through data {channel, word index}.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            empty[c]  = (pushed[c] - popped[c]) <= 0;
            aempty[c] = (pushed[c] - popped[c]) <= 1;
            fdata[c]  = {8'(c), 24'(popped[c])};
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        allow = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_rd got=%b exp=%b", rd, 8'h00); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant); end
        rst_n = 1'b1;
        allow = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req_busy got=%b exp=0", busy); end
        allow = 1'b0;
    endtask

    task automatic test_rr_alternate;
        int exp_g [6];
        int exp_l [6];
        int nb, len, gap, cyc;
        bit in_b;
        logic [N-1:0]  exp_rd;
        logic [DW-1:0] exp_d;
        exp_g = '{2, 5, 2, 5, 2, 5};
        exp_l = '{16, 16, 16, 16, 8, 8};
        nb = 0; len = 0; gap = 0; in_b = 1'b0;
        @(negedge clk);
        pushed[2] += 40;
        pushed[5] += 40;
        allow = 1'b1;
        for (cyc = 0; cyc < 400 && nb < 6; cyc++) begin
            @(negedge clk);
            if (rx_valid) begin
                if (!in_b) begin
                    in_b = 1'b1;
                    len  = 0;
                    checks++; if (grant !== 3'(exp_g[nb])) begin errors++; $display("FAIL rr_grant burst=%0d got=%0d exp=%0d", nb, grant, exp_g[nb]); end
                    if (nb > 0) begin
                        checks++; if (gap !== 2) begin errors++; $display("FAIL rr_gap burst=%0d got=%0d exp=2", nb, gap); end
                    end
                end
                exp_rd = '0;
                exp_rd[exp_g[nb]] = 1'b1;
                exp_d = {8'(exp_g[nb]), 24'(popped[exp_g[nb]])};
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rr_rd got=%b exp=%b", rd, exp_rd); end
                checks++; if (rx_data !== exp_d) begin errors++; $display("FAIL rr_data got=%h exp=%h", rx_data, exp_d); end
                len++;
            end else begin
                if (in_b) begin
                    checks++; if (len !== exp_l[nb]) begin errors++; $display("FAIL rr_len burst=%0d got=%0d exp=%0d", nb, len, exp_l[nb]); end
                    nb++;
                    in_b = 1'b0;
                    gap  = 0;
                end
                gap++;
            end
        end
        checks++; if (nb !== 6) begin errors++; $display("FAIL rr_bursts_seen got=%0d exp=6", nb); end
        checks++; if (pushed[2] - popped[2] !== 0) begin errors++; $display("FAIL rr_ch2_left got=%0d exp=0", pushed[2] - popped[2]); end
        checks++; if (pushed[5] - popped[5] !== 0) begin errors++; $display("FAIL rr_ch5_left got=%0d exp=0", pushed[5] - popped[5]); end
        allow = 1'b0;
    endtask

    task automatic test_almost_empty;
        int pulses;
        bit prev;
        pulses = 0; prev = 1'b0;
        @(negedge clk);
        pushed[3] += 3;
        allow = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (rx_valid) begin
                pulses++;
                checks++; if (grant !== 3'd3) begin errors++; $display("FAIL ae_grant got=%0d exp=3", grant); end
            end else if (prev) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ae_exit_busy got=%b exp=0", busy); end
            end
            prev = rx_valid;
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL ae_pulses got=%0d exp=3", pulses); end
        checks++; if (grant !== 3'd3) begin errors++; $display("FAIL ae_grant_hold got=%0d exp=3", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ae_idle got=%b exp=0", busy); end
        allow = 1'b0;
    endtask

    task automatic test_allow_drop;
        int n, nb, cyc;
        int exp_g [3];
        bit prev;
        exp_g = '{2, 3, 1};
        n = 0;
        @(negedge clk);
        pushed[1] += 40;
        pushed[2] += 2;
        pushed[3] += 2;
        allow = 1'b1;
        for (cyc = 0; cyc < 100 && n < 7; cyc++) begin
            @(negedge clk);
            if (rx_valid) begin
                n++;
                checks++; if (grant !== 3'd1) begin errors++; $display("FAIL drop_grant got=%0d exp=1", grant); end
            end
        end
        checks++; if (n !== 7) begin errors++; $display("FAIL drop_words got=%0d exp=7", n); end
        @(negedge clk);
        allow = 1'b0;
        #1;
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL drop_rd_same_cycle got=%b exp=%b", rd, 8'h00); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL drop_valid got=%b exp=0", rx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_still_burst got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_next got=%b exp=0", busy); end
        checks++; if (pushed[1] - popped[1] !== 33) begin errors++; $display("FAIL drop_ch1_left got=%0d exp=33", pushed[1] - popped[1]); end
        allow = 1'b1;
        nb = 0; prev = 1'b0;
        for (cyc = 0; cyc < 100 && nb < 3; cyc++) begin
            @(negedge clk);
            if (rx_valid && !prev) begin
                checks++; if (grant !== 3'(exp_g[nb])) begin errors++; $display("FAIL drop_order idx=%0d got=%0d exp=%0d", nb, grant, exp_g[nb]); end
                nb++;
            end
            prev = rx_valid;
        end
        checks++; if (nb !== 3) begin errors++; $display("FAIL drop_bursts_seen got=%0d exp=3", nb); end
        for (cyc = 0; cyc < 200 && (pushed[1] - popped[1] != 0 || busy); cyc++) @(negedge clk);
        checks++; if (pushed[1] - popped[1] !== 0) begin errors++; $display("FAIL drop_drain got=%0d exp=0", pushed[1] - popped[1]); end
        allow = 1'b0;
    endtask

    task automatic test_wrap;
        int nb, cyc, left;
        int exp_g [9];
        bit prev;
        exp_g = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pushed[0] += 20;
        for (int c = 1; c < N; c++) pushed[c] += 2;
        allow = 1'b1;
        nb = 0; prev = 1'b0;
        for (cyc = 0; cyc < 300 && nb < 9; cyc++) begin
            @(negedge clk);
            if (rx_valid && !prev) begin
                checks++; if (grant !== 3'(exp_g[nb])) begin errors++; $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", nb, grant, exp_g[nb]); end
                nb++;
            end
            prev = rx_valid;
        end
        checks++; if (nb !== 9) begin errors++; $display("FAIL wrap_bursts_seen got=%0d exp=9", nb); end
        for (cyc = 0; cyc < 100 && (pushed[0] - popped[0] != 0 || busy); cyc++) @(negedge clk);
        left = 0;
        for (int c = 0; c < N; c++) left += pushed[c] - popped[c];
        checks++; if (left !== 0) begin errors++; $display("FAIL wrap_drain got=%0d exp=0", left); end
        allow = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        int n, cyc;
        bit seen;
        n = 0;
        @(negedge clk);
        pushed[6] += 30;
        allow = 1'b1;
        for (cyc = 0; cyc < 50 && n < 3; cyc++) begin
            @(negedge clk);
            if (rx_valid) n++;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL rstmid_words got=%0d exp=3", n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid_async got=%b exp=0", rx_valid); end
        checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rstmid_rd_async got=%b exp=%b", rd, 8'h00); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge clk);
        pushed[0] += 3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            if (rx_valid) begin
                seen = 1'b1;
                checks++; if (grant !== 3'd0) begin errors++; $display("FAIL rstmid_first_grant got=%0d exp=0", grant); end
            end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstmid_no_burst got=%b exp=1", seen); end
        for (cyc = 0; cyc < 200 && (pushed[6] - popped[6] != 0 || busy); cyc++) @(negedge clk);
        checks++; if (pushed[6] - popped[6] !== 0) begin errors++; $display("FAIL rstmid_drain got=%0d exp=0", pushed[6] - popped[6]); end
        allow = 1'b0;
    endtask

`ifdef RR_ARB_CH0_PRIORITY_EN
    task automatic test_ch0_priority;
        int nb, cyc;
        int exp_g [4];
        bit prev;
        exp_g = '{0, 0, 0, 4};
        @(negedge clk);
        pushed[0] += 40;
        pushed[4] += 5;
        allow = 1'b1;
        nb = 0; prev = 1'b0;
        for (cyc = 0; cyc < 200 && nb < 4; cyc++) begin
            @(negedge clk);
            if (rx_valid && !prev) begin
                checks++; if (grant !== 3'(exp_g[nb])) begin errors++; $display("FAIL prio_order idx=%0d got=%0d exp=%0d", nb, grant, exp_g[nb]); end
                nb++;
            end
            prev = rx_valid;
        end
        checks++; if (nb !== 4) begin errors++; $display("FAIL prio_bursts_seen got=%0d exp=4", nb); end
        for (cyc = 0; cyc < 100 && busy; cyc++) @(negedge clk);
        allow = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rr_alternate();
        test_almost_empty();
        test_allow_drop();
        test_wrap();
        test_reset_mid_burst();
`ifdef RR_ARB_CH0_PRIORITY_EN
        test_ch0_priority();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_rx_arbiter.md
RR_RX_ARBITER -- requirements
Module: rr_rx_arbiter

Interface
REQ-001 Parameter NUM_CHANNELS, default 8, number of peripheral RX FIFOs arbitrated (2..16).
REQ-002 Parameter DATA_W, default 32, FIFO and FT601 data width in bits.
REQ-003 Parameter BURST_LEN, default 16, maximum words read per grant (1..256).
REQ-004 Parameter GRANT_W, default $clog2(NUM_CHANNELS), width of the grant index.
REQ-005 clk  input  1  single clock; all state is updated on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_fifo_empty  input  NUM_CHANNELS  per-channel FIFO empty flag.
REQ-008 rx_fifo_almost_empty  input  NUM_CHANNELS  per-channel flag meaning one word or fewer remains.
REQ-009 rx_fifo_data  input  NUM_CHANNELS x DATA_W  per-channel first-word-fall-through read data.
REQ-010 allow_rx  input  1  FT601 controller has the USB bus turned toward the host.
REQ-011 rx_fifo_rd  output  NUM_CHANNELS  one-hot read strobe to the granted FIFO.
REQ-012 rx_data  output  DATA_W  rx_fifo_data of the granted channel.
REQ-013 grant  output  GRANT_W  index of the channel owning the bus.
REQ-014 rx_valid  output  1  rx_data is a valid word being transferred to the FT601 this cycle.
REQ-015 busy  output  1  high in SETUP and BURST.

Function
REQ-016 FSM states SHALL be IDLE, SETUP and BURST.
REQ-017 In IDLE, when allow_rx=1 and at least one rx_fifo_empty bit is 0, the FSM SHALL latch the winner into grant and last_grant and move to SETUP.
REQ-018 The winner SHALL be the first non-empty channel found when searching upward from last_grant+1, wrapping at NUM_CHANNELS-1 back to 0.
REQ-019 SETUP SHALL last exactly one cycle with rx_fifo_rd=0 and rx_valid=0, then the FSM SHALL move to BURST.
REQ-020 In BURST, rx_fifo_rd[grant] SHALL equal allow_rx AND NOT rx_fifo_empty[grant]; all other rx_fifo_rd bits SHALL be 0.
REQ-021 rx_valid SHALL equal the OR of rx_fifo_rd; in all states rx_data SHALL be the combinational mux of rx_fifo_data[grant].
REQ-022 An 8-bit word counter SHALL clear on entry to BURST and increment on each read.
REQ-023 BURST SHALL return to IDLE after any of these conditions:
- a read with counter = BURST_LEN-1;
- a read with rx_fifo_almost_empty[grant]=1;
- a cycle with rx_fifo_empty[grant]=1;
- a cycle with allow_rx=0.
REQ-024 grant SHALL hold its value in IDLE until the next arbitration win.
REQ-025 An exit and a new request in the same cycle SHALL NOT re-arbitrate in that cycle; re-arbitration occurs in IDLE one cycle later (minimum one idle cycle between bursts).
REQ-026 A channel whose empty flag rises during SETUP SHALL cause BURST to exit on its first cycle with zero reads.

Reset
REQ-027 While rst_n=0 the block SHALL hold:
- state = IDLE, grant = 0, last_grant = NUM_CHANNELS-1, counter = 0;
- rx_fifo_rd = 0, rx_valid = 0, busy = 0.
REQ-028 Reset asserted mid-burst SHALL drop rx_fifo_rd and rx_valid immediately, without waiting for a clock edge.
REQ-029 After reset release, the first arbitration SHALL favour channel 0.

Configuration
REQ-030 When macro RR_ARB_CH0_PRIORITY_EN is defined, channel 0 SHALL win every arbitration in which it is non-empty, and round-robin SHALL apply only among channels 1..NUM_CHANNELS-1.
REQ-031 When RR_ARB_CH0_PRIORITY_EN is undefined, all channels SHALL be pure round-robin per REQ-018.

Verification
REQ-032 Reset release; channels 2 and 5 non-empty with 40 words each; allow_rx=1 -> bursts alternate 2,5,2,5, each burst 16 words except the final short one, with one SETUP and one IDLE cycle between bursts.
REQ-033 Channel 3 holds 3 words, almost_empty rises with 1 left -> exactly 3 rx_valid pulses, then IDLE; grant remains 3.
REQ-034 allow_rx dropped after word 7 of a burst on channel 1 -> rx_fifo_rd=0 in that same cycle; IDLE next; channel 1 is served again only after the other requesters.
REQ-035 All 8 channels non-empty, last_grant=7 -> grant sequence 0,1,...,7,0 (wrap-around).
REQ-036 rst_n pulsed low mid-burst -> rx_valid falls asynchronously; next grant is channel 0 if it is non-empty.
REQ-037 With RR_ARB_CH0_PRIORITY_EN defined, channels 0 and 4 always non-empty -> grant stays 0 on every burst; channel 4 is granted only after channel 0 is drained.
